// File: rtl/muldiv_unit_pkg.sv
// Shared funct3 encodings and operand-signedness helpers for the
// RV32M multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  // funct3[2] splits the M ops into multiply and divide halves.
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // Whether rs1 is interpreted as two's complement for this op.
  function automatic logic signed_a(input logic [2:0] f);
    logic s;
    s = 1'b0;
    unique case (f)
      FNC_MUL,
      FNC_MULH,
      FNC_MULHSU,
      FNC_DIV,
      FNC_REM:  s = 1'b1;
      default:  s = 1'b0;
    endcase
    return s;
  endfunction

  // Whether rs2 is interpreted as two's complement for this op.
  function automatic logic signed_b(input logic [2:0] f);
    logic s;
    s = 1'b0;
    unique case (f)
      FNC_MUL,
      FNC_MULH,
      FNC_DIV,
      FNC_REM:  s = 1'b1;
      default:  s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, valid/ready in and out.
// Ports: Clock, Reset_n, in_valid/in_ready, funct, A, B, flush,
//   out_valid/out_ready, Out.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         funct_q, funct_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   out_q, out_d;

  logic               accept;
  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   spec_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_res;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Out       = out_q;

  // flush wins over a request presented in the same cycle.
  assign accept = in_valid & in_ready & ~flush;

  // Operand magnitudes and signs, taken straight off the request.
  always_comb begin
    sa    = signed_a(funct) & A[WIDTH-1];
    sb    = signed_b(funct) & B[WIDTH-1];
    a_mag = sa ? (~A + 1'b1) : A;
    b_mag = sb ? (~B + 1'b1) : B;
  end

  // RISC-V defined results that bypass the iteration entirely.
  always_comb begin
    div_zero = is_div(funct) & (B == '0);
    div_ovf  = ((funct == FNC_DIV) | (funct == FNC_REM))
             & (A == MIN_NEG) & (B == '1);
    spec_res = '0;
    if (div_zero) begin
      spec_res = funct[1] ? A : '1;
    end else if (div_ovf) begin
      spec_res = funct[1] ? '0 : MIN_NEG;
    end
  end

  // Shift-add step: low half holds the remaining multiplier bits,
  // high half accumulates; carry out lands in the top bit.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring step: partial remainder can need WIDTH+1 bits after
  // the shift, so the trial subtract is one bit wider.
  always_comb begin
    rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_ext - {1'b0, b_q};
    if (!diff[WIDTH]) begin
      div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and half select.
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    unique case (funct_q)
      FNC_MUL:    fix_res = prod[WIDTH-1:0];
      FNC_MULH,
      FNC_MULHSU,
      FNC_MULHU:  fix_res = prod[2*WIDTH-1:WIDTH];
      FNC_DIV:    fix_res = (neg_a_q ^ neg_b_q) ? (~quo + 1'b1) : quo;
      FNC_DIVU:   fix_res = quo;
      FNC_REM:    fix_res = neg_a_q ? (~rem + 1'b1) : rem;
      FNC_REMU:   fix_res = rem;
      default:    fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    funct_d = funct_q;
    b_d     = b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct_d = funct;
          cnt_d   = '0;
          if (div_zero | div_ovf) begin
            out_d   = spec_res;
            state_d = S_DONE;
          end else begin
            neg_a_d = sa;
            neg_b_d = sb;
            b_d     = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = is_div(funct_q) ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        out_d   = fix_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      funct_q <= '0;
      b_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      funct_q <= funct_d;
      b_q     <= b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

endmodule
